sample_collector: RTL and testbench

SAMPLE_COLLECTOR -- requirements
Module: sample_collector

---
 rtl/coll_pkg.sv | 14 +
 rtl/coll_chan.sv | 63 ++++++
 rtl/sample_collector.sv | 166 ++++++++++++++++
 tb/tb_sample_collector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coll_pkg.sv
// Shared state encoding and default sizing for the sample collector.
package coll_pkg;
    localparam int DEF_N_CH      = 4;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_LEN_W     = 16;
    localparam int DEF_STUCK_LIM = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } coll_state_e;
endpackage

// File: rtl/coll_chan.sv
// One sample channel: shift register feeding the word packer, plus a run-length
// stuck detector that exists only when COLL_STUCK_EN is defined.
module coll_chan #(
    parameter int WORD_W    = 32,
    parameter int STUCK_LIM = 64
)(
    input  logic              clk200,
    input  logic              rstn,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              samp,
    output logic [WORD_W-1:0] word_next,
    output logic              stuck
);
    logic [WORD_W-2:0] shreg;

    // word_next is the register value after this cycle's shift, so a completing
    // word includes the bit arriving on its last cycle.
    assign word_next = {shreg, samp};

    always_ff @(posedge clk200) begin
        if (!rstn) begin
            shreg <= '0;
        end else if (clr) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= word_next[WORD_W-2:0];
        end
    end

`ifdef COLL_STUCK_EN
    localparam int RUN_W = $clog2(STUCK_LIM + 1);

    logic [RUN_W-1:0] run;
    logic             stuck_q;

    always_ff @(posedge clk200) begin
        if (!rstn) begin
            run     <= '0;
            stuck_q <= 1'b0;
        end else if (clr) begin
            run     <= '0;
            stuck_q <= 1'b0;
        end else if (shift_en) begin
            // run == 0 marks the first bit of a window: nothing to compare against yet
            if (run == '0 || samp == shreg[0]) begin
                if (run != RUN_W'(STUCK_LIM)) begin
                    run <= run + 1'b1;
                end
                if (run == RUN_W'(STUCK_LIM - 1)) begin
                    stuck_q <= 1'b1;
                end
            end else begin
                run <= RUN_W'(1);
            end
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0 & (STUCK_LIM > 0);
`endif
endmodule

// File: rtl/sample_collector.sv
// Packs N_CH raw 1-bit channels into WORD_W-bit words over a StartColl window and
// streams each word set out channel by channel. COLL_STUCK_EN adds stuck detection.
module sample_collector
    import coll_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int STUCK_LIM = DEF_STUCK_LIM,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
)(
    input  logic              clk200,
    input  logic              rstn,
    input  logic              StartColl,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [N_CH-1:0]   samp_i,
    output logic              Collect,
    output logic [WORD_W-1:0] word_o,
    output logic [CH_W-1:0]   ch_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              done_o,
    output logic              ovf_o,
    output logic [N_CH-1:0]   stuck_o,
    output coll_state_e       dbg_state
);
    localparam int BIT_W = $clog2(WORD_W);

    coll_state_e       state, state_next;
    logic              start_prev;
    logic              start_edge;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  word_cnt_inc;
    logic [BIT_W-1:0]  bit_cnt;
    logic              pending;
    logic [CH_W-1:0]   out_ch;
    logic              ovf;
    logic              clr;
    logic              shift_en;
    logic              set_done;
    logic              xfer;
    logic [WORD_W-1:0] hold      [N_CH];
    logic [WORD_W-1:0] chan_next [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        coll_chan #(
            .WORD_W    (WORD_W),
            .STUCK_LIM (STUCK_LIM)
        ) u_chan (
            .clk200    (clk200),
            .rstn      (rstn),
            .clr       (clr),
            .shift_en  (shift_en),
            .samp      (samp_i[g]),
            .word_next (chan_next[g]),
            .stuck     (stuck_o[g])
        );
    end

    // Handshake: valid_o is high while a held word set still has words to hand out;
    // a word moves on every cycle where valid_o and ready_i are both high, and
    // word_o/ch_o hold steady on any cycle where valid_o is high but ready_i is low.
    assign valid_o   = pending;
    assign word_o    = hold[out_ch];
    assign ch_o      = out_ch;
    assign xfer      = pending & ready_i;
    assign Collect   = (state == COLLECT);
    assign done_o    = (state == DONE);
    assign ovf_o     = ovf;
    assign dbg_state = state;

    // Reset leaves start_prev high so a StartColl already high at release is not an edge.
    assign start_edge   = StartColl & ~start_prev;
    assign word_cnt_inc = (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        shift_en   = 1'b0;
        set_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    clr        = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (!StartColl) begin
                    state_next = DRAIN;
                end else begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                        set_done = 1'b1;
                        if (len_q != '0 && word_cnt_inc == len_q) begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk200) begin
        if (!rstn) begin
            state      <= IDLE;
            start_prev <= 1'b1;
            len_q      <= '0;
            word_cnt   <= '0;
            bit_cnt    <= '0;
            pending    <= 1'b0;
            out_ch     <= '0;
            ovf        <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            state      <= state_next;
            start_prev <= StartColl;

            if (clr) begin
                len_q    <= len_i;
                word_cnt <= '0;
                bit_cnt  <= '0;
                ovf      <= 1'b0;
            end

            if (shift_en) begin
                bit_cnt <= set_done ? '0 : bit_cnt + 1'b1;
            end

            if (xfer) begin
                if (out_ch == CH_W'(N_CH - 1)) begin
                    pending <= 1'b0;
                    out_ch  <= '0;
                end else begin
                    out_ch <= out_ch + 1'b1;
                end
            end

            // A set finishing while the previous one is still draining is dropped.
            if (set_done) begin
                word_cnt <= word_cnt_inc;
                if (pending) begin
                    ovf <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    out_ch  <= '0;
                    hold    <= chan_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_collector.sv
// Self-checking bench for sample_collector: per-cycle reference model plus a
// vector table of windows and hand-written corner sequences.
module tb_sample_collector;
    import coll_pkg::*;

    localparam int N_CH   = 4;
    localparam int WORD_W = 8;
    localparam int LEN_W  = 16;
`ifdef COLL_STUCK_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif
    localparam int STUCK_LIM = 64;

    logic              clk200 = 1'b0;
    logic              rstn;
    logic              StartColl;
    logic [LEN_W-1:0]  len_i;
    logic [N_CH-1:0]   samp_i;
    logic              ready_i;
    logic              Collect;
    logic [WORD_W-1:0] word_o;
    logic [1:0]        ch_o;
    logic              valid_o;
    logic              done_o;
    logic              ovf_o;
    logic [N_CH-1:0]   stuck_o;
    coll_state_e       dbg_state;

    sample_collector #(
        .N_CH   (N_CH),
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk200    (clk200),
        .rstn      (rstn),
        .StartColl (StartColl),
        .len_i     (len_i),
        .samp_i    (samp_i),
        .Collect   (Collect),
        .word_o    (word_o),
        .ch_o      (ch_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .done_o    (done_o),
        .ovf_o     (ovf_o),
        .stuck_o   (stuck_o),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk200 = ~clk200;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 collecting, 2 draining, 3 done
    int                m_phase = 0;
    bit                m_prev  = 1'b1;
    int                m_len   = 0;
    int                m_sets  = 0;
    bit                m_ovf   = 1'b0;
    logic [N_CH-1:0]   m_stuck = '0;
    int                m_run  [N_CH];
    bit                m_last [N_CH];
    logic [N_CH-1:0]   hist[$];
    logic [WORD_W-1:0] exp_q[$];
    int                exp_ch_q[$];

    // observed DUT activity
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] got_words = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic coll_state_e phase_state(int p);
        case (p)
            1:       return COLLECT;
            2:       return DRAIN;
            3:       return DONE;
            default: return IDLE;
        endcase
    endfunction

    function automatic void model_edge();
        bit pend;
        bit edge_seen;
        logic [WORD_W-1:0] w;
        if (!rstn) begin
            m_phase = 0; m_prev = 1'b1; m_ovf = 1'b0; m_stuck = '0;
            m_len = 0; m_sets = 0;
            hist.delete(); exp_q.delete(); exp_ch_q.delete();
            return;
        end
        pend      = (exp_q.size() != 0);
        edge_seen = StartColl && !m_prev;
        m_prev    = StartColl;
        case (m_phase)
            0: if (edge_seen) begin
                m_phase = 1; m_len = int'(len_i); m_sets = 0;
                m_ovf = 1'b0; m_stuck = '0; hist.delete();
                for (int c = 0; c < N_CH; c++) m_run[c] = 0;
            end
            1: if (!StartColl) begin
                m_phase = 2;
            end else begin
                hist.push_back(samp_i);
                for (int c = 0; c < N_CH; c++) begin
                    if (m_run[c] == 0 || samp_i[c] == m_last[c])
                        m_run[c] = (m_run[c] < STUCK_LIM) ? m_run[c] + 1 : STUCK_LIM;
                    else
                        m_run[c] = 1;
                    m_last[c] = samp_i[c];
                    if (STUCK_EN && m_run[c] >= STUCK_LIM) m_stuck[c] = 1'b1;
                end
                if (hist.size() == WORD_W) begin
                    if (m_sets < 65535) m_sets++;
                    if (pend) begin
                        m_ovf = 1'b1;
                    end else begin
                        for (int c = 0; c < N_CH; c++) begin
                            w = '0;
                            foreach (hist[k]) w = {w[WORD_W-2:0], hist[k][c]};
                            exp_q.push_back(w);
                            exp_ch_q.push_back(c);
                        end
                    end
                    hist.delete();
                    if (m_len != 0 && m_sets == m_len) m_phase = 2;
                end
            end
            2: if (!pend) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (pend && ready_i) begin
            void'(exp_q.pop_front());
            void'(exp_ch_q.pop_front());
        end
    endfunction

    function automatic void check_outputs();
        chk("collect", Collect, m_phase == 1);
        chk("valid", valid_o, exp_q.size() != 0);
        chk("done", done_o, m_phase == 3);
        chk("ovf", ovf_o, m_ovf);
        chk("stuck", stuck_o, m_stuck);
        chk("state", dbg_state, phase_state(m_phase));
        if (exp_q.size() != 0) begin
            chk("word", word_o, exp_q[0]);
            chk("ch", ch_o, exp_ch_q[0]);
        end
        if (done_o) done_cnt++;
    endfunction

    // driver tasks
    task automatic step();
        if (valid_o && ready_i) begin
            if (xfer_cnt < N_CH) got_words[int'(ch_o)*WORD_W +: WORD_W] = word_o;
            xfer_cnt++;
        end
        @(posedge clk200);
        model_edge();
        @(negedge clk200);
        check_outputs();
    endtask

    task automatic clear_obs();
        xfer_cnt = 0; done_cnt = 0; got_words = '0;
    endtask

    task automatic wait_done(input bit rnd);
        int c;
        c = 0;
        while (!(done_cnt > 0 && m_phase == 0) && c < 300) begin
            ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            samp_i  = N_CH'($urandom);
            step();
            c++;
        end
        chk("done_wait_in_budget", (done_cnt > 0 && m_phase == 0), 1'b1);
        step();
    endtask

    task automatic run_window(input logic [LEN_W-1:0] len, input int hold,
                              input logic [N_CH-1:0] sv, input bit rnd);
        clear_obs();
        len_i = len; StartColl = 1'b1;
        for (int c = 0; c < hold; c++) begin
            samp_i  = rnd ? N_CH'($urandom) : sv;
            ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            len_i = LEN_W'($urandom);
        end
        StartColl = 1'b0;
        wait_done(rnd);
    endtask

    typedef struct {
        logic [LEN_W-1:0] len;
        int               hold;
        logic [N_CH-1:0]  samp;
        bit               rnd;
        int               exp_xfer;
        bit               chk_words;
        logic [31:0]      exp_words;
    } vec_t;

    vec_t vecs[8];
    logic [N_CH-1:0] s_log[64];
    logic [31:0]     ew;

    initial begin
        vecs[0] = '{16'd2, 40, 4'b1010, 1'b0, 8, 1'b1, 32'hFF00FF00};
        vecs[1] = '{16'd0, 21, 4'b0110, 1'b0, 8, 1'b1, 32'h00FFFF00};
        vecs[2] = '{16'd1, 40, 4'b1111, 1'b0, 4, 1'b1, 32'hFFFFFFFF};
        vecs[3] = '{16'd5, 17, 4'b0001, 1'b0, 8, 1'b1, 32'h000000FF};
        vecs[4] = '{16'd3,  9, 4'b1000, 1'b0, 4, 1'b1, 32'hFF000000};
        vecs[5] = '{16'd0,  5, 4'b0000, 1'b0, 0, 1'b0, 32'h0};
        vecs[6] = '{16'd2, 40, 4'b0000, 1'b1, -1, 1'b0, 32'h0};
        vecs[7] = '{16'd0, 30, 4'b0000, 1'b1, -1, 1'b0, 32'h0};

        // reset with StartColl already high: release must not start a window
        rstn = 1'b0; StartColl = 1'b1; len_i = '0; samp_i = '0; ready_i = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk("rst_word", word_o, 0);
        chk("rst_ch", ch_o, 0);
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("no_start_at_release", Collect, 1'b0);
        StartColl = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            run_window(vecs[v].len, vecs[v].hold, vecs[v].samp, vecs[v].rnd);
            chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            if (vecs[v].exp_xfer >= 0) begin
                chk($sformatf("v%0d_xfers", v), xfer_cnt, vecs[v].exp_xfer);
                chk($sformatf("v%0d_ovf", v), ovf_o, 1'b0);
            end
            if (vecs[v].chk_words) chk($sformatf("v%0d_words", v), got_words, vecs[v].exp_words);
        end

        // backpressure: one set held, later sets dropped, drain waits for ready
        clear_obs();
        len_i = 16'd3; StartColl = 1'b1; ready_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            samp_i = N_CH'($urandom); s_log[c] = samp_i;
            step();
        end
        chk("bp_state_drain", dbg_state, DRAIN);
        chk("bp_valid", valid_o, 1'b1);
        chk("bp_ovf", ovf_o, 1'b1);
        chk("bp_no_done", done_cnt, 0);
        StartColl = 1'b0;
        wait_done(1'b0);
        chk("bp_xfers", xfer_cnt, 4);
        ew = '0;
        for (int k = 1; k <= WORD_W; k++)
            for (int c = 0; c < N_CH; c++)
                ew[c*WORD_W +: WORD_W] = {ew[c*WORD_W +: WORD_W-1], s_log[k][c]};
        chk("bp_first_set_kept", got_words, ew);

        // reset while a set is waiting to go out
        clear_obs();
        len_i = 16'd0; StartColl = 1'b1; ready_i = 1'b0;
        for (int c = 0; c < 14; c++) begin
            samp_i = N_CH'($urandom);
            step();
        end
        chk("mid_valid_before_rst", valid_o, 1'b1);
        rstn = 1'b0;
        step();
        chk("mrst_collect", Collect, 1'b0);
        chk("mrst_valid", valid_o, 1'b0);
        chk("mrst_word", word_o, 0);
        chk("mrst_ch", ch_o, 0);
        chk("mrst_state", dbg_state, IDLE);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("mrst_no_restart", Collect, 1'b0);
        StartColl = 1'b0;
        step();
        run_window(16'd1, 20, 4'b0101, 1'b0);
        chk("post_rst_xfers", xfer_cnt, 4);
        chk("post_rst_words", got_words, 32'h00FF00FF);

        // one channel held at 1 for the stuck limit while the others toggle
        clear_obs();
        len_i = 16'd0; StartColl = 1'b1; ready_i = 1'b1;
        for (int c = 0; c < 70; c++) begin
            samp_i = {c[0], 1'b1, ~c[0], c[0]};
            step();
        end
        chk("stuck_flags", stuck_o, STUCK_EN ? 4'b0100 : 4'b0000);
        StartColl = 1'b0;
        wait_done(1'b0);
        chk("stuck_sticky_idle", stuck_o, STUCK_EN ? 4'b0100 : 4'b0000);
        StartColl = 1'b1; samp_i = 4'b0101;
        step();
        step();
        chk("stuck_cleared_on_start", stuck_o, 4'b0000);
        StartColl = 1'b0;
        wait_done(1'b0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
